// File: rtl/fm_tx_pkg.sv
// Shared definitions for the FM transmit path: sequencer states and
// low-pass accumulator constants.
package fm_tx_pkg;

  localparam int              ACC_W     = 25;
  localparam logic [15:0]     MIDSCALE  = 16'h8000;
  localparam logic [24:0]     ACC_RESET = 25'h1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_HP    = 2'd2,
    ST_SUM   = 2'd3
  } state_t;

endpackage

// File: rtl/sat_s2u16.sv
// Signed-to-16-bit-unsigned saturator: negative clamps to 0, anything above
// 65535 clamps to 0xFFFF. Also used by the modulator gain stage.
module sat_s2u16 #(
  parameter int IN_W = 21
) (
  input  logic signed [IN_W-1:0] s,
  output logic        [15:0]     y
);

  always_comb begin
    if (s[IN_W-1])
      y = 16'h0000;
    else if (|s[IN_W-2:16])
      y = 16'hFFFF;
    else
      y = s[15:0];
  end

endmodule

// File: rtl/preemph.sv
// FM pre-emphasis high-shelf: y = x + 2^GAIN_SHIFT * (x - lp(x)), saturated.
// Optional sticky saturation flag when PREEMPH_CLIP_FLAG_EN is defined.
//
// state | meaning
// IDLE  | wait for in_tick, capture sample
// LATCH | save previous low-pass output, update accumulator
// HP    | high-pass difference and boost
// SUM   | add boost to sample, saturate, pulse out_tick
module preemph
  import fm_tx_pkg::*;
#(
  parameter int GAIN_SHIFT = 2,
  parameter int ACC_W      = fm_tx_pkg::ACC_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] xin,
  input  logic        in_tick,
`ifdef PREEMPH_CLIP_FLAG_EN
  input  logic        clip_clr,
  output logic        clip,
`endif
  output logic [15:0] yout,
  output logic        out_tick
);

  localparam int BW = 18 + GAIN_SHIFT;
  localparam int SW = BW + 1;

  state_t state, state_nxt;
  logic   ld_x, upd_acc, calc_hp, do_sum;

  logic [15:0]            x_reg;
  logic [15:0]            lp_prev;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_d;
  logic signed [16:0]     hp_d;
  logic signed [BW-1:0]   boost;
  logic signed [BW-1:0]   boost_d;
  logic signed [SW-1:0]   s_d;
  logic [15:0]            sat_y;

  always_ff @(posedge CLK) begin
    if (RST)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_tick) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_HP;
      ST_HP:    state_nxt = ST_SUM;
      ST_SUM:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_x    = (state == ST_IDLE) && in_tick;
    upd_acc = (state == ST_LATCH);
    calc_hp = (state == ST_HP);
    do_sum  = (state == ST_SUM);
  end

  // 507/512 = 1 - 1/128 - 1/512; input weight 5 = 4 + 1
  assign acc_d   = acc - (acc >> 7) - (acc >> 9)
                 + ACC_W'({x_reg, 2'b00}) + ACC_W'(x_reg);
  // lp_prev is the low-pass value before this sample's update
  assign hp_d    = $signed({1'b0, x_reg}) - $signed({1'b0, lp_prev});
  assign boost_d = BW'(hp_d) <<< GAIN_SHIFT;
  assign s_d     = $signed({{(SW-16){1'b0}}, x_reg}) + SW'(boost);

  sat_s2u16 #(.IN_W(SW)) u_sat (
    .s (s_d),
    .y (sat_y)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_reg    <= MIDSCALE;
      lp_prev  <= MIDSCALE;
      acc      <= ACC_W'(ACC_RESET);
      boost    <= '0;
      yout     <= MIDSCALE;
      out_tick <= 1'b0;
    end else begin
      out_tick <= do_sum;
      if (ld_x)
        x_reg <= xin;
      if (upd_acc) begin
        lp_prev <= acc[9 +: 16];
        acc     <= acc_d;
      end
      if (calc_hp)
        boost <= boost_d;
      if (do_sum)
        yout <= sat_y;
    end
  end

`ifdef PREEMPH_CLIP_FLAG_EN
  logic sat_hit;
  assign sat_hit = s_d[SW-1] | (|s_d[SW-2:16]);

  // set beats clear when both land together
  always_ff @(posedge CLK) begin
    if (RST)
      clip <= 1'b0;
    else if (do_sum && sat_hit)
      clip <= 1'b1;
    else if (clip_clr)
      clip <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_preemph.sv
// Scoreboard bench for preemph: stimulus pushes reference outputs, a monitor
// pops and compares on every out_tick (value and arrival cycle).
module tb_preemph;

  localparam int G = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] xin = 16'h8000;
  logic        in_tick = 1'b0;
  logic [15:0] yout;
  logic        out_tick;
`ifdef PREEMPH_CLIP_FLAG_EN
  logic        clip_clr = 1'b0;
  logic        clip;
`endif

  always #5 CLK = ~CLK;

  preemph #(.GAIN_SHIFT(G)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .xin      (xin),
    .in_tick  (in_tick),
`ifdef PREEMPH_CLIP_FLAG_EN
    .clip_clr (clip_clr),
    .clip     (clip),
`endif
    .yout     (yout),
    .out_tick (out_tick)
  );

  typedef struct {
    int y;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_y = 32768;
  int   n_out  = 0;
  int   m_acc  = 1 << 24;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: output uses the low-pass value before this sample updates it.
  task automatic ref_step(input int x, output int y);
    int lp;
    lp = m_acc / 512;
    y  = x + (x - lp) * (1 << G);
    if (y < 0)          y = 0;
    else if (y > 65535) y = 65535;
    m_acc = m_acc - m_acc / 128 - m_acc / 512 + 5 * x;
  endtask

  always @(negedge CLK) begin
    if (out_tick) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_tick: got pulse yout=%0d at cycle %0d, expected none", yout, cyc);
      end else begin
        e = sb.pop_front();
        chk("yout", int'(yout), e.y);
        chk("latency", cyc, e.at);
      end
      last_y = int'(yout);
      n_out++;
    end
  end

  task automatic send(input logic [15:0] x, input int gap);
    int y;
    exp_t e;
    @(posedge CLK); #1;
    xin     = x;
    in_tick = 1'b1;
    ref_step(int'(x), y);
    e.y  = y;
    e.at = cyc + 4;
    sb.push_back(e);
    @(posedge CLK); #1;
    in_tick = 1'b0;
    repeat (gap - 1) @(posedge CLK);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 50) begin
      @(posedge CLK);
      k++;
    end
    @(negedge CLK);
    chk("drain_outstanding", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST     = 1'b1;
    in_tick = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST   = 1'b0;
    m_acc = 1 << 24;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n0;
    exp_t e;
    int y;

    do_reset();
    @(negedge CLK);
    chk("reset_yout", int'(yout), 32768);
    chk("reset_out_tick", int'(out_tick), 0);

    // in_tick together with reset: sample is discarded
    n0 = n_out;
    @(posedge CLK); #1;
    RST = 1'b1; in_tick = 1'b1; xin = 16'h0000;
    @(posedge CLK); #1;
    RST = 1'b0; in_tick = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tick_no_out", n_out - n0, 0);
    chk("rst_tick_yout", int'(yout), 32768);

    for (int i = 0; i < 10; i++) send(16'h8000, 4);
    drain();
    chk("silence_yout", last_y, 32768);

    // step of +1000 then settle
    for (int i = 0; i < 2000; i++) send(16'h83E8, 4);
    drain();
    chk("step_settled", int'(last_y >= 16'h83E6 && last_y <= 16'h83EA), 1);

    do_reset();
    send(16'h0000, 4);
    drain();
    chk("neg_sat_yout", last_y, 0);
`ifdef PREEMPH_CLIP_FLAG_EN
    chk("clip_set", int'(clip), 1);
    send(16'h8000, 4);
    drain();
    chk("clip_sticky", int'(clip), 1);
    @(posedge CLK); #1 clip_clr = 1'b1;
    @(posedge CLK); #1 clip_clr = 1'b0;
    @(negedge CLK);
    chk("clip_cleared", int'(clip), 0);
`endif

    do_reset();
    for (int i = 0; i < 4000; i++) send(16'hFFFF, 4);
    drain();
    chk("pos_hold", int'(last_y >= 16'hFFFD), 1);

    // extra in_tick 1 and 2 cycles after an accepted one
    do_reset();
    n0 = n_out;
    @(posedge CLK); #1;
    xin = 16'h9000; in_tick = 1'b1;
    ref_step(16'h9000, y);
    e.y = y; e.at = cyc + 4;
    sb.push_back(e);
    @(posedge CLK); #1 xin = 16'h1234;
    @(posedge CLK); #1 xin = 16'hF000;
    @(posedge CLK); #1 in_tick = 1'b0;
    repeat (6) @(posedge CLK);
    drain();
    chk("ignored_ticks_outs", n_out - n0, 1);

    // reset while the sequencer is in HP
    n0 = n_out;
    @(posedge CLK); #1;
    xin = 16'h0000; in_tick = 1'b1;
    @(posedge CLK); #1 in_tick = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    m_acc = 1 << 24;
    @(negedge CLK);
    chk("hp_rst_yout", int'(yout), 32768);
    chk("hp_rst_out_tick", int'(out_tick), 0);
    repeat (6) @(posedge CLK);
    chk("hp_rst_no_out", n_out - n0, 0);
    send(16'h8000, 4);
    send(16'hA000, 5);
    drain();

    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x;
      case ($urandom_range(0, 7))
        0:       x = 16'h0000;
        1:       x = 16'hFFFF;
        default: x = 16'($urandom_range(0, 65535));
      endcase
      send(x, int'($urandom_range(4, 12)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
